// File: rtl/alu_op_sequencer.sv
// Program buffer and issue FSM that steps a queued list of register-register ALU ops
// through the datapath, holding operands SETTLE cycles before a single write pulse.
module alu_op_sequencer #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned SETTLE = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_valid,
  input  logic [14:0]              load_instr,
  output logic                     load_ready,
  input  logic                     clear,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   prog_count,
  output logic [3:0]               dp_rs,
  output logic [3:0]               dp_rt,
  output logic [3:0]               dp_rd,
  output logic [3:0]               dp_alu_control,
  output logic                     dp_wrReg,
  input  logic [31:0]              dp_result,
  output logic [31:0]              last_result
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWrite = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [PW:0]   count_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [SW-1:0] settle_q, settle_d;
  logic          load_en;
  logic [14:0]   instr_d;
  logic          drive_ops;

  logic [14:0] prog_mem [DEPTH];

  always_comb begin
    state_d  = state_q;
    count_d  = prog_count;
    pc_d     = pc_q;
    settle_d = settle_q;
    load_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // clear empties the buffer first, so a same-cycle start sees an empty program
        if (clear) begin
          count_d = '0;
          if (start) state_d = StDone;
        end else if (start) begin
          if (prog_count != '0) begin
            state_d  = StIssue;
            pc_d     = '0;
            settle_d = '0;
          end else begin
            state_d = StDone;
          end
        end else if (load_valid && load_ready) begin
          load_en = 1'b1;
          count_d = prog_count + (PW+1)'(1);
        end
      end
      StIssue: begin
        if (settle_q == SW'(SETTLE - 1)) state_d = StWrite;
        else                              settle_d = settle_q + SW'(1);
      end
      StWrite: begin
        if ({1'b0, pc_q} == prog_count - (PW+1)'(1)) begin
          state_d = StDone;
        end else begin
          pc_d     = pc_q + PW'(1);
          settle_d = '0;
          state_d  = StIssue;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state they describe
  assign instr_d   = prog_mem[pc_d];
  assign drive_ops = (state_d == StIssue) || (state_d == StWrite);

  always_ff @(posedge clk) begin
    if (load_en) prog_mem[prog_count[PW-1:0]] <= load_instr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      prog_count     <= '0;
      pc_q           <= '0;
      settle_q       <= '0;
      load_ready     <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      dp_rs          <= '0;
      dp_rt          <= '0;
      dp_rd          <= '0;
      dp_alu_control <= '0;
      dp_wrReg       <= 1'b0;
      last_result    <= '0;
    end else begin
      state_q    <= state_d;
      prog_count <= count_d;
      pc_q       <= pc_d;
      settle_q   <= settle_d;
      load_ready <= (state_d == StIdle) && (count_d < (PW+1)'(DEPTH));
      busy       <= (state_d != StIdle);
      done       <= (state_d == StDone);
      dp_wrReg   <= (state_d == StWrite);
      if (drive_ops) begin
        dp_rd          <= instr_d[11:8];
        dp_rs          <= instr_d[7:4];
        dp_rt          <= instr_d[3:0];
        dp_alu_control <= {1'b0, instr_d[14:12]};
      end else begin
        dp_rd          <= '0;
        dp_rs          <= '0;
        dp_rt          <= '0;
        dp_alu_control <= '0;
      end
      if (state_q == StWrite) last_result <= dp_result;
    end
  end

endmodule
